fp_normalizer: RTL
==================

Name: fp_normalizer

Overview:
- Post-add/subtract normalization stage of the FP ALU, the opposite direction to the exponent-alignment right shifter.
- Takes the raw 25-bit significand sum (carry bit plus 24 bits) and the tentative exponent.
- Shifts left one bit per cycle, decrementing the exponent, until the hidden bit (bit 23) is 1; handles carry-out, zero, underflow and overflow.
- Feeds the rounding/pack stage through a load/done handshake.

Parameters:
- MW, 24, significand width including hidden bit (carry bit is MW+1).
- EW, 8, exponent width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  start; sampled only in IDLE.
- mant_in  input  25  raw significand; bit 24 = carry-out of the adder.
- exp_in  input  8  tentative (larger) exponent.
- mant_out  output  24  normalized significand.
- exp_out  output  8  adjusted exponent.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- overflow  output  1  sticky until next accepted load.
- underflow  output  1  sticky until next accepted load.

Behaviour:
- Reset (async, any state including mid-shift): state IDLE; mant_out=0, exp_out=0, busy=0, done=0, overflow=0, underflow=0. No partial result survives.
- States: IDLE, SHIFT, DONE.
- IDLE, load=1: clear overflow and underflow, then decode in priority order:
  - exp_in==255 (Inf/NaN): pass through. mant_out=mant_in[23:0], exp_out=255. Go to DONE.
  - mant_in==0: mant_out=0, exp_out=0 (exact zero). Go to DONE.
  - mant_in[24]=1: mant_out=mant_in[24:1], exp_out=exp_in+1. Go to DONE.
    - If exp_in==254: exp_out=255, mant_out=0, overflow=1.
  - Otherwise: mant_out=mant_in[23:0], exp_out=exp_in. Go to SHIFT.
- SHIFT, evaluated each cycle in this order:
  - mant_out[23]=1: go to DONE.
  - exp_out<=1: underflow=1, exp_out=0, mant_out unchanged (denormal). Go to DONE.
  - Otherwise: mant_out<<=1 (zero fill), exp_out-=1. Stay in SHIFT.
- DONE: done=1 for exactly one cycle, then IDLE.
- Outputs hold their value in IDLE until the next accepted load.
- load while busy is ignored; no queueing.
- Latency from the load sampling edge:
  - Fast paths (Inf/NaN, zero, carry): done high in the following cycle (1 cycle).
  - Shift path with k leading zeros in mant_in[23:0] (0≤k≤23): done high k+2 cycles after load.
- Worst case is 25 cycles.
- Exponent arithmetic is 8-bit unsigned. Exponent never wraps: the underflow check precedes the decrement, and overflow saturates to 255.

Optional Feature:
- FP_NORM_LZC_FAST_EN defined:
  - SHIFT resolves in a single cycle using a leading-zero count lz.
  - Shift amount s = min(lz, exp_out-1); mant_out<<=s, exp_out-=s.
  - If lz>exp_out-1: exp_out=0, underflow=1.
  - Go to DONE. Shift-path latency is fixed at 2 cycles.
- Undefined: iterative one-bit-per-cycle behaviour as above.
- Final mant_out, exp_out and flags are identical in both builds.

Decomposition:
- Shared package fp_alu_pkg holds:
  - State enum (IDLE/SHIFT/DONE).
  - MW/EW constants.
  - EXP_MAX=255.
  - EXP_INF_OVF=254.
- One sub-module, lzc24: combinational 24-bit leading-zero counter, 5-bit output, returns 24 for all-zero input. Instantiated only under FP_NORM_LZC_FAST_EN.

Test Plan:
- Already normalized: mant_in=0x0800000, exp_in=100 -> done after 2 cycles; mant_out=0x800000, exp_out=100, no flags.
- Shift path: mant_in=0x0000100 (k=15), exp_in=100 -> mant_out=0x800000, exp_out=85, done at cycle 17 (iterative) / cycle 2 (fast).
- Carry and overflow:
  - mant_in=0x1800000, exp_in=10 -> mant_out=0xC00000, exp_out=11, 1-cycle latency.
  - Same mant_in with exp_in=254 -> exp_out=255, mant_out=0, overflow=1.
- Underflow: mant_in=0x0000001, exp_in=3 -> exp_out=0, underflow=1, mant_out=0x000004.
- Zero: mant_in=0 -> mant_out=0, exp_out=0.
- Inf/NaN passthrough: exp_in=255, mant_in=0x0400001 -> unchanged.
- Control robustness:
  - Assert reset 3 cycles into a k=15 shift -> all outputs 0, state IDLE.
  - A load pulsed while busy is ignored; a subsequent load is accepted normally.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared FP ALU definitions: significand/exponent widths, special exponents
// and the normalizer state encoding.
package fp_alu_pkg;

  localparam int MW = 24;
  localparam int EW = 8;

  localparam logic [EW-1:0] EXP_MAX     = 8'd255;
  localparam logic [EW-1:0] EXP_INF_OVF = 8'd254;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lzc24.sv
// Combinational 24-bit leading-zero counter; an all-zero input yields 24.
module lzc24 (
  input  logic [23:0] value,
  output logic [4:0]  count
);

  // Scan upward so the highest set bit makes the final assignment.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (value[i]) begin
        count = 5'(23 - i);
      end
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// Post-add/subtract normalizer: takes the 25-bit raw significand sum and the
// tentative exponent, left-shifts until the hidden bit is set, and reports
// carry, zero, Inf/NaN, underflow and overflow cases.
// Optional build macro FP_NORM_LZC_FAST_EN: resolve the whole left shift in
// a single cycle using a leading-zero counter instead of one bit per cycle.
module fp_normalizer
  import fp_alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [MW:0]   mant_in,
  input  logic [EW-1:0] exp_in,
  output logic [MW-1:0] mant_out,
  output logic [EW-1:0] exp_out,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic          underflow
);

  state_t        state, state_nxt;
  logic [MW-1:0] mant_nxt;
  logic [EW-1:0] exp_nxt;
  logic          ovf_nxt, udf_nxt;

`ifdef FP_NORM_LZC_FAST_EN
  logic [4:0]    lz;
  logic [EW-1:0] lz_ext, exp_m1, shamt;

  lzc24 u_lzc (
    .value (mant_out),
    .count (lz)
  );

  assign lz_ext = {{(EW-5){1'b0}}, lz};
  assign exp_m1 = exp_out - 8'd1;
  assign shamt  = (lz_ext < exp_m1) ? lz_ext : exp_m1;
`endif

  assign busy = (state == SHIFT) || (state == DONE);
  assign done = (state == DONE);

  // State and result registers; reset wipes any partial result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mant_out  <= '0;
      exp_out   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      mant_out  <= mant_nxt;
      exp_out   <= exp_nxt;
      overflow  <= ovf_nxt;
      underflow <= udf_nxt;
    end
  end

  // Next-state and datapath decode; everything holds unless a case updates it.
  always_comb begin
    state_nxt = state;
    mant_nxt  = mant_out;
    exp_nxt   = exp_out;
    ovf_nxt   = overflow;
    udf_nxt   = underflow;
    case (state)
      IDLE: begin
        if (load) begin
          ovf_nxt   = 1'b0;
          udf_nxt   = 1'b0;
          state_nxt = DONE;
          if (exp_in == EXP_MAX) begin
            mant_nxt = mant_in[MW-1:0];
            exp_nxt  = EXP_MAX;
          end else if (mant_in == '0) begin
            mant_nxt = '0;
            exp_nxt  = '0;
          end else if (mant_in[MW]) begin
            if (exp_in == EXP_INF_OVF) begin
              mant_nxt = '0;
              exp_nxt  = EXP_MAX;
              ovf_nxt  = 1'b1;
            end else begin
              mant_nxt = mant_in[MW:1];
              exp_nxt  = exp_in + 8'd1;
            end
          end else begin
            mant_nxt  = mant_in[MW-1:0];
            exp_nxt   = exp_in;
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
`ifdef FP_NORM_LZC_FAST_EN
        state_nxt = DONE;
        if (lz != 5'd0) begin
          if (exp_out <= 8'd1) begin
            exp_nxt = '0;
            udf_nxt = 1'b1;
          end else begin
            mant_nxt = mant_out << shamt;
            if (lz_ext > exp_m1) begin
              exp_nxt = '0;
              udf_nxt = 1'b1;
            end else begin
              exp_nxt = exp_out - shamt;
            end
          end
        end
`else
        if (mant_out[MW-1]) begin
          state_nxt = DONE;
        end else if (exp_out <= 8'd1) begin
          udf_nxt   = 1'b1;
          exp_nxt   = '0;
          state_nxt = DONE;
        end else begin
          mant_nxt = {mant_out[MW-2:0], 1'b0};
          exp_nxt  = exp_out - 8'd1;
        end
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
